pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Hazard/control unit that drives the stall and bubble inputs of every pipeline register (F,D,E,M,W) in the
//  Y86-64 pipelined core. It detects load/use hazards, RET, mispredicted JXX and exceptions, and tracks the
//  sticky processor status (RUN/DRAIN/HALTED). It also keeps saturating performance counters.
//  It sits beside the datapath: it reads stage icodes, register IDs and stats, and feeds the F..W pipe_reg instances.
// PARAMETERS
//  CNT_W   32   width of each performance counter (saturating)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  D_icode      in   4      icode in D register
//  E_icode      in   4      icode in E register
//  M_icode      in   4      icode in M register
//  E_dstM       in   4      dstM in E register (4'hF = none)
//  d_srcA       in   4      srcA decoded in D stage
//  d_srcB       in   4      srcB decoded in D stage
//  e_cnd        in   1      condition computed in E stage
//  m_stat       in   2      status leaving M stage
//  W_stat       in   2      status in W register
//  F_stall      out  1      hold F (PC) register
//  D_stall      out  1      hold D register
//  D_bubble     out  1      insert NOP into D
//  E_bubble     out  1      insert NOP into E
//  M_bubble     out  1      insert NOP into M
//  W_bubble     out  1      insert NOP into W (reset only)
//  W_stall      out  1      hold W register
//  cpu_stat     out  2      sticky processor status
//  halted       out  1      1 while state==HALTED
//  cyc_cnt      out  CNT_W  cycles counted in RUN/DRAIN
//  stall_cnt    out  CNT_W  cycles with load/use stall
//  mispred_cnt  out  CNT_W  mispredicted JXX count
//  ret_cnt      out  CNT_W  cycles stalled for RET
// BEHAVIOUR
//  - Encodings: stat AOK=0,HLT=1,ADR=2,INS=3. icode HALT=0,NOP=1,MRMOVQ=5,JXX=7,RET=9,POPQ=B. RNONE=4'hF.
//  - lu  = (E_icode==MRMOVQ|POPQ) & E_dstM!=RNONE & (E_dstM==d_srcA | E_dstM==d_srcB).
//  - ret = RET in any of D_icode,E_icode,M_icode. mp = E_icode==JXX & ~e_cnd.
//  - exc_m = m_stat!=AOK. exc_w = W_stat!=AOK.
//  - State RUN (combinational outputs, 0-cycle latency):
//      F_stall=lu|ret; D_stall=lu; D_bubble=mp|(~lu&ret); E_bubble=mp|lu;
//      M_bubble=exc_m|exc_w; W_stall=exc_w; W_bubble=0.
//  - No register ever receives stall and bubble together. D_stall has priority; D_bubble is forced to 0 when lu.
//  - FSM, updated on posedge clk:
//      RUN->DRAIN on exc_m & ~exc_w. RUN|DRAIN->HALTED on exc_w. HALTED is sticky until rst_n.
//      DRAIN: same equations as RUN (drains older instructions through W).
//  - HALTED: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=W_bubble=0.
//  - cpu_stat: reset AOK. Loads W_stat on the cycle entering HALTED, then holds. halted=1 only in HALTED.
//  - Counters: reset 0, and saturate at all-ones.
//      cyc_cnt: +1 per cycle in RUN/DRAIN.
//      stall_cnt: +1 per cycle with lu.
//      mispred_cnt: +1 per cycle with mp.
//      ret_cnt: +1 per cycle with ret & ~lu.
//      All counters are frozen in HALTED.
//  - While rst_n=0 (async):
//      state=RUN, cpu_stat=AOK, counters=0.
//      Outputs F_stall=1, D/E/M/W_bubble=1, D_stall=W_stall=0.
//  - After rst_n deasserts, normal equations apply from the next cycle. Reset asserted mid-DRAIN/HALTED aborts immediately to RUN.
// STRUCTURE
//  - Package y86_pkg: stat and icode localparams, RNONE, FSM state typedef {RUN,DRAIN,HALTED}.
//  - One sub-module: sat_counter (CNT_W, inc, clk, rst_n), instantiated four times.
// TESTING
//  - Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt 0->1.
//  - Mispredict: E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mispred_cnt +1.
//  - RET: D_icode=9 for 3 cycles, then E, then M -> F_stall=D_bubble=1 each cycle; ret_cnt=3 after those cycles.
//  - RET+load/use together: D_stall=1, D_bubble=0, E_bubble=1.
//  - Exception: m_stat=2 -> M_bubble=1, state DRAIN; next cycle W_stat=2 -> HALTED, cpu_stat=2, halted=1, cyc_cnt frozen.
//  - Reset mid-HALTED: pull rst_n low -> cpu_stat=0, halted=0, counters=0, bubbles=1 immediately (async).
//  - Saturation: CNT_W=4, hold lu for 20 cycles -> stall_cnt=15 and stays at 15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice: status codes,
// icodes, the "no register" ID and the hazard-unit FSM states.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pstate_t;

    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 hazard/control unit: stall/bubble generation for F..W, sticky
// processor status FSM and saturating performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             W_stall,
    output logic [1:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    logic    lu, ret, mp, exc_m, exc_w;
    logic    live_q;
    pstate_t state_q, state_d;
    logic [1:0] stat_q, stat_d;
    logic    cnt_en;

    assign lu    = is_load(E_icode) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp    = (E_icode == I_JXX) && !e_cnd;
    assign exc_m = (m_stat != STAT_AOK);
    assign exc_w = (W_stat != STAT_AOK);

    // live_q stays low through reset and the first edge after release, so the
    // reset-time control pattern is held for one full cycle after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (live_q) begin
            case (state_q)
                RUN: begin
                    if (exc_w) begin
                        state_d = HALTED;
                        stat_d  = W_stat;
                    end else if (exc_m) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (exc_w) begin
                        state_d = HALTED;
                        stat_d  = W_stat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
        W_stall  = 1'b0;
        if (live_q) begin
            if (state_q == HALTED) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_bubble = 1'b0;
                W_stall  = 1'b1;
            end else begin
                // Load/use wins over RET in D: hold D rather than bubble it.
                F_stall  = lu | ret;
                D_stall  = lu;
                D_bubble = mp | (~lu & ret);
                E_bubble = mp | lu;
                M_bubble = exc_m | exc_w;
                W_bubble = 1'b0;
                W_stall  = exc_w;
            end
        end
    end

    assign cpu_stat = stat_q;
    assign halted   = (state_q == HALTED);
    assign cnt_en   = live_q && (state_q != HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst_n(rst_n), .inc(cnt_en), .cnt(cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(cnt_en & lu), .cnt(stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk(clk), .rst_n(rst_n), .inc(cnt_en & mp), .cnt(mispred_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk(clk), .rst_n(rst_n), .inc(cnt_en & ret & ~lu), .cnt(ret_cnt)
    );

endmodule
